// File: rtl/processing_element_ms.sv
// Multi-stationary systolic PE: output-stationary accumulate/drain or weight-stationary psum pass-through.
// Optional PE_SATURATE_EN: saturating accumulator and WS sums instead of modulo wrap.
module processing_element_ms #(
  parameter int WIDTH_A   = 16,
  parameter int WIDTH_B   = 16,
  parameter int WIDTH_MAC = 48,
  parameter int STAGE     = 5,
  parameter int SIGNED    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode_in,
  input  logic                 pipeline_en,
  input  logic                 reg_clear,
  input  logic [WIDTH_A-1:0]   act,
  input  logic                 act_vld,
  input  logic [WIDTH_B-1:0]   wei,
  input  logic                 wei_vld,
  input  logic                 wei_load,
  input  logic [WIDTH_MAC-1:0] psum_in,
  input  logic                 drain_en,
  input  logic [WIDTH_MAC-1:0] drain_in,
  output logic [WIDTH_A-1:0]   act_out,
  output logic                 act_vld_out,
  output logic [WIDTH_B-1:0]   wei_out,
  output logic                 wei_vld_out,
  output logic [WIDTH_MAC-1:0] psum_out,
  output logic                 out_vld,
  output logic                 busy,
  output logic                 mode
);

  localparam bit SGN = (SIGNED != 0);

  typedef logic [WIDTH_MAC-1:0] mac_t;

`ifdef PE_SATURATE_EN
  function automatic mac_t mac_add(input mac_t x, input mac_t y);
    logic [WIDTH_MAC:0] s;
    mac_t r;
    s = {1'b0, x} + {1'b0, y};
    r = s[WIDTH_MAC-1:0];
    if (SGN) begin
      if (x[WIDTH_MAC-1] == y[WIDTH_MAC-1] &&
          s[WIDTH_MAC-1] != x[WIDTH_MAC-1]) begin
        r = x[WIDTH_MAC-1] ? {1'b1, {(WIDTH_MAC-1){1'b0}}}
                           : {1'b0, {(WIDTH_MAC-1){1'b1}}};
      end
    end else if (s[WIDTH_MAC]) begin
      r = '1;
    end
    return r;
  endfunction
`else
  function automatic mac_t mac_add(input mac_t x, input mac_t y);
    mac_t r;
    r = x + y;
    return r;
  endfunction
`endif

  logic               mode_q;
  logic [WIDTH_A-1:0] act_q;
  logic               act_vld_q;
  logic [WIDTH_B-1:0] wei_q;
  logic               wei_vld_q;
  logic [WIDTH_B-1:0] w_stat_q;
  logic [STAGE-1:0]   vld_q;
  mac_t               prod_q [STAGE];
  mac_t               ps_q   [STAGE];
  mac_t               acc_q;
  mac_t               res_q;
  logic               out_vld_q;

  logic               issue_c;
  logic               ret_c;
  logic               drain_c;
  logic [WIDTH_B-1:0] b_sel;
  mac_t               a_mx;
  mac_t               b_mx;
  mac_t               prod_c;
  mac_t               sum_c;
  mac_t               acc_d;
  mac_t               res_d;
  logic               out_vld_d;

  // Operands are extended to the accumulator width before the multiply;
  // the low WIDTH_MAC bits equal the extended native product.
  always_comb begin
    b_sel   = mode_q ? w_stat_q : wei;
    issue_c = act_vld & (mode_q | wei_vld);
    a_mx    = {{(WIDTH_MAC-WIDTH_A){SGN & act[WIDTH_A-1]}}, act};
    b_mx    = {{(WIDTH_MAC-WIDTH_B){SGN & b_sel[WIDTH_B-1]}}, b_sel};
    prod_c  = a_mx * b_mx;
    ret_c   = vld_q[STAGE-1];
    drain_c = drain_en & ~mode_q;
    sum_c   = mac_add(mode_q ? ps_q[STAGE-1] : acc_q,
                      prod_q[STAGE-1]);
    acc_d     = acc_q;
    res_d     = res_q;
    out_vld_d = out_vld_q;
    if (mode_q) begin
      if (ret_c) res_d = sum_c;
      out_vld_d = ret_c;
    end else if (drain_c) begin
      acc_d     = drain_in;
      out_vld_d = 1'b1;
    end else if (ret_c) begin
      acc_d     = sum_c;
      out_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= 1'b0;
      act_q     <= '0;
      act_vld_q <= 1'b0;
      wei_q     <= '0;
      wei_vld_q <= 1'b0;
      w_stat_q  <= '0;
      vld_q     <= '0;
      acc_q     <= '0;
      res_q     <= '0;
      out_vld_q <= 1'b0;
      for (int i = 0; i < STAGE; i++) begin
        prod_q[i] <= '0;
        ps_q[i]   <= '0;
      end
    end else if (reg_clear) begin
      mode_q    <= mode_in;
      act_q     <= '0;
      act_vld_q <= 1'b0;
      wei_q     <= '0;
      wei_vld_q <= 1'b0;
      w_stat_q  <= '0;
      vld_q     <= '0;
      acc_q     <= '0;
      res_q     <= '0;
      out_vld_q <= 1'b0;
      for (int i = 0; i < STAGE; i++) begin
        prod_q[i] <= '0;
        ps_q[i]   <= '0;
      end
    end else if (pipeline_en) begin
      act_q     <= act;
      act_vld_q <= act_vld;
      wei_q     <= wei;
      wei_vld_q <= wei_vld;
      if (mode_q && wei_load && wei_vld) w_stat_q <= wei;
      vld_q[0]  <= issue_c;
      prod_q[0] <= prod_c;
      ps_q[0]   <= psum_in;
      for (int i = 1; i < STAGE; i++) begin
        vld_q[i]  <= vld_q[i-1];
        prod_q[i] <= prod_q[i-1];
        ps_q[i]   <= ps_q[i-1];
      end
      acc_q     <= acc_d;
      res_q     <= res_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign act_out     = act_q;
  assign act_vld_out = act_vld_q;
  assign wei_out     = wei_q;
  assign wei_vld_out = wei_vld_q;
  assign psum_out    = mode_q ? res_q : acc_q;
  assign out_vld     = out_vld_q;
  assign busy        = |vld_q;
  assign mode        = mode_q;

endmodule

// File: tb/tb_processing_element_ms.sv
// Scoreboard bench for processing_element_ms (default parameters, STAGE=5).
// Stimulus pushes cycle-tagged expectations; a monitor compares psum_out/out_vld.
module tb_processing_element_ms;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode_in = 1'b0;
  logic        pipeline_en = 1'b1;
  logic        reg_clear = 1'b0;
  logic [15:0] act = 16'd1;
  logic        act_vld = 1'b1;
  logic [15:0] wei = 16'd1;
  logic        wei_vld = 1'b1;
  logic        wei_load = 1'b0;
  logic [47:0] psum_in = '0;
  logic        drain_en = 1'b0;
  logic [47:0] drain_in = '0;
  logic [15:0] act_out;
  logic        act_vld_out;
  logic [15:0] wei_out;
  logic        wei_vld_out;
  logic [47:0] psum_out;
  logic        out_vld;
  logic        busy;
  logic        mode;

  processing_element_ms dut (
    .clk(clk), .rst_n(rst_n), .mode_in(mode_in),
    .pipeline_en(pipeline_en), .reg_clear(reg_clear),
    .act(act), .act_vld(act_vld), .wei(wei), .wei_vld(wei_vld),
    .wei_load(wei_load), .psum_in(psum_in),
    .drain_en(drain_en), .drain_in(drain_in),
    .act_out(act_out), .act_vld_out(act_vld_out),
    .wei_out(wei_out), .wei_vld_out(wei_vld_out),
    .psum_out(psum_out), .out_vld(out_vld),
    .busy(busy), .mode(mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [47:0] ps;
    logic        vld;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   e;
  logic [47:0] sat_exp;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [47:0] p, input logic v);
    exp_t x;
    x.cyc = c;
    x.ps  = p;
    x.vld = v;
    sb.push_back(x);
  endtask

  task automatic wait_sb();
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL sb_timeout pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compares every expectation tagged with the current edge.
  initial forever begin
    exp_t x;
    @(posedge clk);
    #1;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      x = sb.pop_front();
      if (x.cyc < cyc) begin
        failures++;
        $display("FAIL sb_missed got=%0d exp=%0d", cyc, x.cyc);
      end else begin
        chk("sb_psum", 64'(psum_out), 64'(x.ps));
        chk("sb_vld", 64'(out_vld), 64'(x.vld));
      end
    end
  end

  initial begin
`ifdef PE_SATURATE_EN
    sat_exp = 48'hFFFF_FFFF_FFFF;
`else
    sat_exp = 48'h0;
`endif
    // Reset held with active operands
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("rst_psum", 64'(psum_out), 0);
    chk("rst_vld", 64'(out_vld), 0);
    chk("rst_act_out", 64'(act_out), 0);
    chk("rst_wvld_out", 64'(wei_vld_out), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_mode", 64'(mode), 0);
    rst_n = 1'b1;
    e = cyc + 1;
    push(e + 4, 48'd0, 1'b0);
    push(e + 5, 48'd1, 1'b1);
    @(negedge clk);
    act_vld = 1'b0;
    wei_vld = 1'b0;
    chk("fwd_act", 64'(act_out), 1);
    chk("fwd_wvld", 64'(wei_vld_out), 1);
    chk("busy_on", 64'(busy), 1);
    wait_sb();

    // OS back-to-back accumulation
    reg_clear = 1'b1;
    @(negedge clk);
    reg_clear = 1'b0;
    chk("clr_psum", 64'(psum_out), 0);
    act = 16'd1; wei = 16'd1; act_vld = 1'b1; wei_vld = 1'b1;
    e = cyc + 1;
    push(e + 4, 48'd0, 1'b0);
    push(e + 5, 48'd1, 1'b1);
    push(e + 6, 48'd5, 1'b1);
    push(e + 7, 48'd14, 1'b1);
    @(negedge clk);
    act = 16'd2; wei = 16'd2;
    @(negedge clk);
    act = 16'd3; wei = 16'd3;
    @(negedge clk);
    act_vld = 1'b0; wei_vld = 1'b0;
    wait_sb();

    // Stall for 10 cycles mid-flight
    reg_clear = 1'b1;
    @(negedge clk);
    reg_clear = 1'b0;
    act = 16'd2; wei = 16'd2; act_vld = 1'b1; wei_vld = 1'b1;
    e = cyc + 1;
    push(e + 14, 48'd0, 1'b0);
    push(e + 15, 48'd4, 1'b1);
    @(negedge clk);
    act = 16'd9; act_vld = 1'b0; wei_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    pipeline_en = 1'b0;
    act = 16'h33;
    @(negedge clk);
    chk("stall_act", 64'(act_out), 9);
    chk("stall_busy", 64'(busy), 1);
    repeat (9) @(negedge clk);
    chk("stall_act_end", 64'(act_out), 9);
    chk("stall_psum", 64'(psum_out), 0);
    pipeline_en = 1'b1;
    @(negedge clk);
    chk("resume_act", 64'(act_out), 16'h33);
    wait_sb();
    pipeline_en = 1'b0;
    reg_clear = 1'b1;
    @(negedge clk);
    chk("stallclr_psum", 64'(psum_out), 0);
    chk("stallclr_vld", 64'(out_vld), 0);
    reg_clear = 1'b0;
    pipeline_en = 1'b1;

    // WS: stationary weight, psum pass-through, drain ignored
    mode_in = 1'b1;
    reg_clear = 1'b1;
    @(negedge clk);
    reg_clear = 1'b0;
    chk("ws_mode", 64'(mode), 1);
    drain_en = 1'b1; drain_in = 48'hAA;
    wei = 16'd3; wei_vld = 1'b1; wei_load = 1'b1;
    @(negedge clk);
    act = 16'd4; act_vld = 1'b1; psum_in = 48'd10; wei_load = 1'b0;
    e = cyc + 1;
    push(e + 4, 48'd0, 1'b0);
    push(e + 5, 48'd22, 1'b1);
    push(e + 6, 48'd7, 1'b1);
    push(e + 7, 48'd5, 1'b1);
    push(e + 8, 48'd5, 1'b0);
    @(negedge clk);
    act = 16'd2; psum_in = 48'd1; wei = 16'd5; wei_load = 1'b1;
    @(negedge clk);
    act = 16'd1; psum_in = 48'd0; wei_load = 1'b0;
    @(negedge clk);
    act_vld = 1'b0; wei_vld = 1'b0;
    wait_sb();
    drain_en = 1'b0;

    // OS drain, then saturation/wrap boundary
    mode_in = 1'b0;
    reg_clear = 1'b1;
    @(negedge clk);
    reg_clear = 1'b0;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    chk("drain_busy", 64'(busy), 0);
    drain_en = 1'b1; drain_in = 48'h55; mode_in = 1'b1;
    e = cyc + 1;
    push(e, 48'h55, 1'b1);
    push(e + 1, 48'hFFFF_FFFF_FFFE, 1'b1);
    push(e + 7, sat_exp, 1'b1);
    @(negedge clk);
    drain_in = 48'hFFFF_FFFF_FFFE;
    @(negedge clk);
    drain_en = 1'b0;
    act = 16'd2; wei = 16'd1; act_vld = 1'b1; wei_vld = 1'b1;
    @(negedge clk);
    act_vld = 1'b0; wei_vld = 1'b0;
    chk("mode_hold", 64'(mode), 0);
    wait_sb();

    // Clear wins over a simultaneous issue
    mode_in = 1'b0;
    reg_clear = 1'b1;
    act = 16'd3; wei = 16'd3; act_vld = 1'b1; wei_vld = 1'b1;
    e = cyc + 1;
    push(e, 48'd0, 1'b0);
    push(e + 5, 48'd0, 1'b0);
    @(negedge clk);
    reg_clear = 1'b0; act_vld = 1'b0; wei_vld = 1'b0;
    chk("clrissue_busy", 64'(busy), 0);
    wait_sb();

    // Asynchronous reset mid-flight
    act = 16'd1; wei = 16'd1; act_vld = 1'b1; wei_vld = 1'b1;
    @(negedge clk);
    act_vld = 1'b0; wei_vld = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_act", 64'(act_out), 0);
    chk("arst_busy", 64'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("arst_psum", 64'(psum_out), 0);
    chk("arst_vld", 64'(out_vld), 0);

    wait_sb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
